// File: rtl/decoder_nx_seq.sv
// decoder_nx_seq: registered N-to-2^N one-hot decoder with valid/ready load and timed sweep.
// Define DECODER_ACTIVE_LOW_EN for 74x138-style inverted y outputs.
module decoder_nx_seq #(
    parameter int N       = 3,
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [N-1:0]       sel,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               sweep_start,
    input  logic [DWELL_W-1:0] dwell,
    output logic [(1<<N)-1:0]  y,
    output logic               y_valid,
    output logic               busy,
    output logic               sweep_done
);
    localparam int M = 1 << N;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t             state;
    logic [M-1:0]       hot;
    logic [N-1:0]       idx;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] dwell_q;

    assign in_ready = (state == IDLE) && en && !sweep_start;

`ifdef DECODER_ACTIVE_LOW_EN
    assign y = ~hot;
`else
    assign y = hot;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            hot        <= '0;
            idx        <= '0;
            cnt        <= '0;
            dwell_q    <= '0;
            y_valid    <= 1'b0;
            busy       <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            y_valid    <= 1'b0;
            sweep_done <= 1'b0;
            if (!en) begin
                state <= IDLE;
                hot   <= '0;
                busy  <= 1'b0;
            end else if (state == IDLE) begin
                if (sweep_start) begin
                    state   <= SWEEP;
                    busy    <= 1'b1;
                    idx     <= '0;
                    hot     <= M'(1);
                    cnt     <= dwell;
                    dwell_q <= dwell;
                    y_valid <= 1'b1;
                end else if (in_valid) begin
                    hot     <= M'(1) << sel;
                    y_valid <= 1'b1;
                end
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else if (idx != '1) begin
                // walking the one-hot left is the same as decoding idx+1
                idx     <= idx + 1'b1;
                hot     <= hot << 1;
                cnt     <= dwell_q;
                y_valid <= 1'b1;
            end else begin
                state      <= IDLE;
                hot        <= '0;
                busy       <= 1'b0;
                sweep_done <= 1'b1;
            end
        end
    end
endmodule

// File: doc/decoder_nx_seq.md
Name: decoder_nx_seq

Overview:
Parametrised registered N-to-2^N one-hot decoder. It extends the 3x8 combinational decoder with an enable, a valid/ready input handshake, and a self-timed sweep mode that walks the one-hot output across every code with a programmable dwell. It is used as a select/strobe generator for downstream banks, such as LED scan, chip-select fan-out and test walking-ones.

Parameters:
N, 3, select width; output width is 2^N.
DWELL_W, 4, width of the dwell-count input.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
en  input  1  block enable; low forces outputs inactive and aborts a sweep
sel  input  N  code to decode in direct mode
in_valid  input  1  sel is valid this cycle
in_ready  output  1  block accepts sel this cycle
sweep_start  input  1  request an automatic sweep over all codes
dwell  input  DWELL_W  sampled at sweep start; each code is held dwell+1 cycles
y  output  2^N  registered one-hot decode
y_valid  output  1  one-cycle pulse when a new code is loaded into y
busy  output  1  high while a sweep is in progress
sweep_done  output  1  one-cycle pulse when a sweep completes normally

Behaviour:
- Reset, asynchronous: state=IDLE, y=0, y_valid=0, busy=0, sweep_done=0, internal idx=0, internal cnt=0.
- States: IDLE and SWEEP.
- in_ready is combinational and equals (state==IDLE) && en && !sweep_start. While rst is asserted it follows en && !sweep_start.
- IDLE, direct mode:
  - An accept (in_valid && in_ready) loads y <= 1<<sel on the next edge and pulses y_valid=1 for one cycle. Latency is 1 cycle.
  - With no accept, y holds its value and y_valid=0.
- IDLE, sweep start:
  - Condition: sweep_start && en. sweep_start has priority over in_valid in the same cycle; sel is not accepted.
  - Next edge: state=SWEEP, busy=1, idx=0, y=1, cnt=dwell (dwell is latched), y_valid pulses.
- SWEEP:
  - Each cycle with cnt!=0: cnt decrements and y holds.
  - When cnt==0 and idx<2^N-1: idx increments, y <= 1<<(idx+1), cnt reloads the latched dwell, y_valid pulses.
  - When cnt==0 and idx==2^N-1: next edge returns to IDLE with y=0, busy=0, sweep_done pulsed for 1 cycle, and y_valid=0.
  - Total sweep duration is 2^N*(dwell+1) cycles from the first y load to the last y cycle.
  - dwell=0 gives one cycle per code.
  - sweep_start and in_valid are ignored during SWEEP.
- en low:
  - In any state, the next edge gives y=0, y_valid=0, busy=0, state=IDLE.
  - An aborted sweep does not assert sweep_done.
  - en has priority over all other inputs.
- rst mid-sweep: outputs return to reset values immediately; sweep_done is not asserted.
- Widths: idx is N bits, cnt is DWELL_W bits, and the idx compare is against the all-ones value of N bits. y is always zero or one-hot.

Optional Feature:
- Macro: DECODER_ACTIVE_LOW_EN.
- When defined: the y port is the bitwise inverse of the internal one-hot value, giving 74x138-style active-low outputs.
  - The reset value and the inactive/aborted value of y become all ones.
  - The selected bit is 0.
  - y_valid, busy, sweep_done and in_ready are unchanged.
- When not defined: y is active-high as described above.

Test Plan:
1. Assert rst with N=3 -> y=00000000, y_valid=0, busy=0, sweep_done=0. After release with en=1 and sweep_start=0 -> in_ready=1.
2. en=1, in_valid=1, sel=5 for one cycle -> next cycle y=00100000 with y_valid=1; the following cycle y=00100000 with y_valid=0. Repeat for sel=0..7 -> y=1<<sel each time.
3. en=0 with in_valid=1, sel=2 -> in_ready=0, y=00000000, y_valid never asserted.
4. sweep_start=1, dwell=2 -> y=00000001 for 3 cycles, then 00000010 for 3 cycles, and so on through 10000000 for 3 cycles (24 cycles total). Expect 8 y_valid pulses, busy=1 throughout, then y=0, busy=0 and a single sweep_done pulse.
5. sweep_start=1 and in_valid=1 with sel=6 in the same cycle, dwell=0 -> sweep runs (y=00000001 first), sel=6 is not loaded, in_ready=0 that cycle. in_valid pulses mid-sweep are ignored.
6. Sweep with dwell=3; drop en while y=00001000 -> next cycle y=0, busy=0, no sweep_done. Repeat with rst asserted mid-sweep instead of en low -> immediate reset values. With DECODER_ACTIVE_LOW_EN defined, rerun scenario 2 -> sel=5 gives y=11011111 and reset gives 11111111.
